primitive_ap_n: RTL and testbench

- Parametrised successor to the fixed-count stream-apply primitives (ap01/ap02).
- Per call, pops N elements from an input stream and presents them as N simple outputs. Then forwards the stream remainder on a stream output.
- N, element width and an optional registered stream-output stage are generic.
- Sits between poprc-compiled blocks using the standard sync handshake and stream valid/ready signalling.

---
 rtl/primitive_ap_n_pkg.sv | 4 +
 rtl/primitive_ap_n_stream_skid.sv | 34 +++
 rtl/primitive_ap_n.sv | 87 ++++++++
 tb/tb_primitive_ap_n.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/primitive_ap_n_pkg.sv
// primitive_ap_n_pkg: shared state encoding for the stream-apply primitives
package primitive_ap_n_pkg;
    typedef enum logic [1:0] {AP_IDLE, AP_COLLECT, AP_DONE, AP_PASS} ap_state_t;
endpackage

// File: rtl/primitive_ap_n_stream_skid.sv
// stream_skid: two-deep registered stream slice, full throughput under backpressure
module stream_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [1:0] cnt;
    logic [W-1:0] d0, d1;
    logic push, pop;
    always_comb begin
        in_ready  = cnt != 2'd2;
        out_valid = cnt != 2'd0;
        out_data  = d0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) d0 <= in_data;
            if (push && cnt == 2'd1 && !pop) d1 <= in_data;
            if (pop && cnt == 2'd2) d0 <= d1;
        end
    end
endmodule

// File: rtl/primitive_ap_n.sv
// primitive_ap_n: pops N stream elements into dOut per call, then forwards the remainder
module primitive_ap_n
    import primitive_ap_n_pkg::*;
#(
    parameter int N       = 2,
    parameter int W       = 8,
    parameter bit OUT_REG = 1'b0
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic [W-1:0]   sIn,
    input  logic           sIn_valid,
    output logic           sIn_ready,
    output logic [W-1:0]   sOut,
    output logic           sOut_valid,
    input  logic           sOut_ready,
    output logic [N*W-1:0] dOut
);
    localparam int CW = $clog2(N + 1);
    ap_state_t state;
    logic [CW-1:0] count;
    logic idle, collect, pass, pass_take, fwd_ready, slice_empty, call;
    always_comb begin
        idle      = state == AP_IDLE;
        collect   = state == AP_COLLECT;
        pass      = state == AP_PASS;
        // a pending call freezes forwarding so the slice can drain and the call is never starved
        pass_take = pass & ~in_valid;
        in_ready  = (idle | pass) & slice_empty;
        sIn_ready = collect | (pass_take & fwd_ready);
        call      = in_valid & in_ready;
    end
    generate
        if (OUT_REG) begin : g_reg
            logic sk_valid, sk_ready;
            stream_skid #(.W(W)) u_skid (
                .clk       (clk),
                .nrst      (nrst),
                .in_data   (sIn),
                .in_valid  (pass_take & sIn_valid),
                .in_ready  (sk_ready),
                .out_data  (sOut),
                .out_valid (sk_valid),
                .out_ready (sOut_ready)
            );
            assign sOut_valid  = sk_valid;
            assign fwd_ready   = sk_ready;
            assign slice_empty = ~sk_valid;
        end else begin : g_comb
            assign sOut        = sIn;
            assign sOut_valid  = pass_take & sIn_valid;
            assign fwd_ready   = sOut_ready;
            assign slice_empty = 1'b1;
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= AP_IDLE;
            count     <= '0;
            dOut      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                AP_COLLECT: if (sIn_valid) begin
                    dOut[count*W +: W] <= sIn;
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state     <= AP_DONE;
                        out_valid <= 1'b1;
                    end
                end
                AP_DONE: if (out_ready) begin
                    state     <= AP_PASS;
                    out_valid <= 1'b0;
                end
                default: if (call) begin
                    state <= AP_COLLECT;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_primitive_ap_n.sv
// tb_primitive_ap_n: directed checks of a pass-through N=2 instance and a registered N=4 instance
module tb_primitive_ap_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_errors = 0;
    logic a_nrst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sIn_valid, a_sIn_ready;
    logic a_sOut_valid, a_sOut_ready;
    logic [7:0] a_sIn, a_sOut;
    logic [15:0] a_dOut;
    logic b_nrst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sIn_valid, b_sIn_ready;
    logic b_sOut_valid, b_sOut_ready;
    logic [7:0] b_sIn, b_sOut;
    logic [31:0] b_dOut;
    primitive_ap_n #(.N(2), .W(8), .OUT_REG(1'b0)) u_a (
        .clk(clk), .nrst(a_nrst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .sIn(a_sIn), .sIn_valid(a_sIn_valid),
        .sIn_ready(a_sIn_ready), .sOut(a_sOut), .sOut_valid(a_sOut_valid),
        .sOut_ready(a_sOut_ready), .dOut(a_dOut)
    );
    primitive_ap_n #(.N(4), .W(8), .OUT_REG(1'b1)) u_b (
        .clk(clk), .nrst(b_nrst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sIn(b_sIn), .sIn_valid(b_sIn_valid),
        .sIn_ready(b_sIn_ready), .sOut(b_sOut), .sOut_valid(b_sOut_valid),
        .sOut_ready(b_sOut_ready), .dOut(b_dOut)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [7:0] nxt, oexp, base;
        logic accepted;
        a_nrst = 0; a_in_valid = 0; a_out_ready = 0; a_sIn = 0; a_sIn_valid = 0; a_sOut_ready = 1;
        b_nrst = 0; b_in_valid = 0; b_out_ready = 0; b_sIn = 0; b_sIn_valid = 0; b_sOut_ready = 0;
        tick(); tick();
        a_nrst = 1;
        check("a_rst_in_ready", 32'(a_in_ready), 1);
        check("a_rst_out_valid", 32'(a_out_valid), 0);
        check("a_rst_dout", 32'(a_dOut), 0);
        check("a_rst_sin_ready", 32'(a_sIn_ready), 0);
        check("a_rst_sout_valid", 32'(a_sOut_valid), 0);
        a_in_valid = 1; tick(); a_in_valid = 0;
        check("a_col_in_ready", 32'(a_in_ready), 0);
        check("a_col_sin_ready", 32'(a_sIn_ready), 1);
        a_sIn = 1; a_sIn_valid = 1; tick();
        a_sIn = 2;
        check("a_col_early", 32'(a_out_valid), 0);
        tick();
        a_sIn = 3;
        check("a_done_valid", 32'(a_out_valid), 1);
        check("a_done_dout", 32'(a_dOut), 32'h0201);
        for (int i = 0; i < 5; i++) begin
            check("a_bp_valid", 32'(a_out_valid), 1);
            check("a_bp_dout", 32'(a_dOut), 32'h0201);
            check("a_bp_sin_ready", 32'(a_sIn_ready), 0);
            tick();
        end
        a_out_ready = 1; tick(); a_out_ready = 0;
        check("a_pass_out_valid", 32'(a_out_valid), 0);
        check("a_pass_sout", 32'(a_sOut), 3);
        check("a_pass_sout_valid", 32'(a_sOut_valid), 1);
        check("a_pass_sin_ready", 32'(a_sIn_ready), 1);
        a_sOut_ready = 0; #1;
        check("a_pass_bp", 32'(a_sIn_ready), 0);
        a_sOut_ready = 1; tick();
        a_sIn = 4; #1;
        check("a_pass_sout2", 32'(a_sOut), 4);
        a_in_valid = 1; #1;
        check("a_recall_sin_ready", 32'(a_sIn_ready), 0);
        check("a_recall_sout_valid", 32'(a_sOut_valid), 0);
        tick(); a_in_valid = 0;
        tick();
        a_sIn_valid = 0; tick();
        check("a_gap_early", 32'(a_out_valid), 0);
        a_sIn = 5; a_sIn_valid = 1; tick();
        check("a_gap_valid", 32'(a_out_valid), 1);
        check("a_gap_dout", 32'(a_dOut), 32'h0504);
        a_out_ready = 1; tick(); a_out_ready = 0;
        a_in_valid = 1; tick(); a_in_valid = 0;
        a_sIn = 6; tick();
        a_nrst = 0; a_sIn_valid = 0; tick(); a_nrst = 1;
        check("a_mrst_out_valid", 32'(a_out_valid), 0);
        check("a_mrst_dout", 32'(a_dOut), 0);
        check("a_mrst_in_ready", 32'(a_in_ready), 1);
        check("a_mrst_sin_ready", 32'(a_sIn_ready), 0);
        a_in_valid = 1; tick(); a_in_valid = 0;
        a_sIn = 7; a_sIn_valid = 1; tick();
        a_sIn = 8; tick();
        a_sIn_valid = 0;
        check("a_fresh_valid", 32'(a_out_valid), 1);
        check("a_fresh_dout", 32'(a_dOut), 32'h0807);
        b_nrst = 1; tick();
        check("b_rst_in_ready", 32'(b_in_ready), 1);
        b_in_valid = 1; tick(); b_in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            b_sIn = 8'(10 + i); b_sIn_valid = 1; #1;
            check("b_col_early", 32'(b_out_valid), 0);
            tick();
        end
        b_sIn_valid = 0;
        check("b_done_valid", 32'(b_out_valid), 1);
        check("b_done_dout", b_dOut, 32'h0D0C0B0A);
        b_out_ready = 1; tick(); b_out_ready = 0;
        nxt = 14; oexp = 14; accepted = 0;
        for (int c = 0; c < 80 && !accepted; c++) begin
            b_sIn = nxt; b_sIn_valid = 1;
            b_sOut_ready = 1'($urandom_range(0, 1));
            b_in_valid = c >= 20;
            #1;
            if (b_sOut_valid && b_sOut_ready) begin
                check("b_sout", 32'(b_sOut), 32'(oexp));
                oexp++;
            end
            if (b_sIn_valid && b_sIn_ready) nxt++;
            if (b_in_valid && b_in_ready) accepted = 1;
            tick();
        end
        b_in_valid = 0;
        check("b_accept", 32'(accepted), 1);
        check("b_drained", 32'(oexp), 32'(nxt));
        base = nxt;
        for (int i = 0; i < 4; i++) begin
            b_sIn = nxt; b_sIn_valid = 1; #1;
            check("b_recol_sin_ready", 32'(b_sIn_ready), 1);
            nxt++;
            tick();
        end
        check("b_recol_valid", 32'(b_out_valid), 1);
        check("b_recol_dout", b_dOut, {8'(base + 3), 8'(base + 2), 8'(base + 1), base});
        b_out_ready = 1; tick(); b_out_ready = 0;
        oexp = nxt;
        for (int c = 0; c < 16; c++) begin
            b_sIn = nxt; b_sIn_valid = 1;
            b_sOut_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_sOut_valid && b_sOut_ready) begin
                check("b_sout_tail", 32'(b_sOut), 32'(oexp));
                oexp++;
            end
            if (b_sIn_valid && b_sIn_ready) nxt++;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
